alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (4-bit ALUControl encoding) between two requesters, e.g. the integer execute path and the branch/address unit.
- Round-robin arbitration with valid/ready handshakes on each request and response channel.
- Drives the shared ALU operands and control code. Captures the ALU result into a one-entry response buffer per requester.
- Sits between the decode/ALU-control stage and the shared ALU.

---
 rtl/alu_share_arbiter_if.sv | 55 +++++
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Request, response and shared-ALU signals of the ALU sharing arbiter.
//   slave  : the arbiter. It takes requests and ALU results, and drives
//            readies, buffered responses, ALU operands and busy.
//   master : the environment. It is the requesters plus the shared ALU.
interface alu_share_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [3:0]      req0_ctrl;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_result;
  logic            rsp0_zero;
  logic            rsp0_err;

  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [3:0]      req1_ctrl;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_result;
  logic            rsp1_zero;
  logic            rsp1_err;

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output alu_a, alu_b, alu_ctrl, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  alu_a, alu_b, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Lets two requesters share one combinational ALU. Arbitration is
//   round-robin and happens in the same cycle as the request. The ALU result
//   is captured into a one-entry response buffer per requester.
// Ports:
//   clk   : clock; all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_share_arbiter_if.slave
//           req0/req1 valid/ready/a/b/ctrl
//           rsp0/rsp1 valid/ready/result/zero/err
//           alu_a/alu_b/alu_ctrl out, alu_result/alu_zero in
//           busy
//
// State (there is no sequencing FSM; these registers are the whole state):
//   reg           | meaning
//   rr_ptr_q      | requester that wins when both are eligible
//   rsp_valid_q   | response buffer holds an unconsumed result
//   rsp_*_q       | buffered result / zero flag / illegal-code flag
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] req_a    [2];
  logic [XLEN-1:0] req_b    [2];
  logic [3:0]      req_ctrl [2];

  logic [1:0]      slot_free;
  logic [1:0]      elig;
  logic [1:0]      grant;
  logic            gnt_any;
  logic            gnt_idx;
  logic [3:0]      sel_ctrl;
  logic            gnt_illegal;

  logic            rr_ptr_q, rr_ptr_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_zero_q, rsp_zero_d;
  logic [1:0]      rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_result_q [2];
  logic [XLEN-1:0] rsp_result_d [2];

  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready   = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a[0]    = bus.req0_a;
  assign req_a[1]    = bus.req1_a;
  assign req_b[0]    = bus.req0_b;
  assign req_b[1]    = bus.req1_b;
  assign req_ctrl[0] = bus.req0_ctrl;
  assign req_ctrl[1] = bus.req1_ctrl;

  // A slot being drained this cycle can be refilled in the same cycle.
  // Gating with rst_n keeps every ready low while reset is held.
  assign slot_free = ~rsp_valid_q | rsp_ready;
  assign elig      = req_valid & slot_free & {2{rst_n}};

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign gnt_any     = |grant;
  assign gnt_idx     = grant[1];
  assign sel_ctrl    = req_ctrl[gnt_idx];
  assign gnt_illegal = gnt_any && (sel_ctrl > 4'd9);

  // An illegal code still goes to the ALU as ADD; its result is discarded.
  assign bus.alu_a    = gnt_any ? req_a[gnt_idx] : '0;
  assign bus.alu_b    = gnt_any ? req_b[gnt_idx] : '0;
  assign bus.alu_ctrl = (gnt_any && !gnt_illegal) ? sel_ctrl : 4'b0000;

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_zero_d      = rsp_zero_q;
    rsp_err_d       = rsp_err_q;
    rsp_result_d[0] = rsp_result_q[0];
    rsp_result_d[1] = rsp_result_q[1];

    if (gnt_any) begin
      rr_ptr_d = ~gnt_idx;
    end

    for (int n = 0; n < 2; n++) begin
      if (grant[n]) begin
        rsp_valid_d[n]  = 1'b1;
        rsp_err_d[n]    = gnt_illegal;
        rsp_zero_d[n]   = !gnt_illegal && bus.alu_zero;
        rsp_result_d[n] = gnt_illegal ? '0 : bus.alu_result;
      end else if (rsp_ready[n]) begin
        rsp_valid_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q        <= 1'b0;
      rsp_valid_q     <= 2'b00;
      rsp_zero_q      <= 2'b00;
      rsp_err_q       <= 2'b00;
      rsp_result_q[0] <= '0;
      rsp_result_q[1] <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_zero_q      <= rsp_zero_d;
      rsp_err_q       <= rsp_err_d;
      rsp_result_q[0] <= rsp_result_d[0];
      rsp_result_q[1] <= rsp_result_d[1];
    end
  end

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = rsp_result_q[0];
  assign bus.rsp1_result = rsp_result_q[1];
  assign bus.rsp0_zero   = rsp_zero_q[0];
  assign bus.rsp1_zero   = rsp_zero_q[1];
  assign bus.rsp0_err    = rsp_err_q[0];
  assign bus.rsp1_err    = rsp_err_q[1];
  assign bus.busy        = |rsp_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed scenarios plus a randomized run. Checks the arbiter against a
//   transaction-level model: per-requester response slots and a "who goes
//   next" preference, with ALU results computed arithmetically.
module tb_alu_share_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.XLEN(XLEN)) bus();

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit          m_valid  [2];
  logic [31:0] m_result [2];
  bit          m_zero   [2];
  bit          m_err    [2];
  bit          m_pref;
  bit          eg       [2];
  logic [31:0] e_a, e_b;
  logic [3:0]  e_ctrl;

  function automatic logic [31:0] alu_ref(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // shared ALU stand-in
  assign bus.alu_result = alu_ref(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic drive_req(input int n, input bit v, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic drive_rsp(input bit r0, input bit r1);
    bus.rsp0_ready = r0;
    bus.rsp1_ready = r1;
  endtask

  task automatic idle_all();
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_rsp(1'b0, 1'b0);
  endtask

  task automatic get_req(input int n, output bit v, output logic [3:0] c,
                         output logic [31:0] a, output logic [31:0] b);
    if (n == 0) begin
      v = bus.req0_valid; c = bus.req0_ctrl; a = bus.req0_a; b = bus.req0_b;
    end else begin
      v = bus.req1_valid; c = bus.req1_ctrl; a = bus.req1_a; b = bus.req1_b;
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_valid[n] = 1'b0; m_result[n] = 32'd0; m_zero[n] = 1'b0; m_err[n] = 1'b0;
    end
    m_pref = 1'b0;
  endtask

  // Expected grants and ALU drive for the inputs currently applied.
  task automatic predict();
    bit          v [2];
    logic [3:0]  c [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    bit          rr [2];
    bit          el [2];
    for (int n = 0; n < 2; n++) get_req(n, v[n], c[n], a[n], b[n]);
    rr[0] = bus.rsp0_ready;
    rr[1] = bus.rsp1_ready;
    for (int n = 0; n < 2; n++) el[n] = rst_n && v[n] && (!m_valid[n] || rr[n]);
    eg[0] = 1'b0;
    eg[1] = 1'b0;
    if (el[0] && el[1]) eg[m_pref] = 1'b1;
    else begin
      eg[0] = el[0];
      eg[1] = el[1];
    end
    e_a = 32'd0; e_b = 32'd0; e_ctrl = 4'd0;
    for (int n = 0; n < 2; n++) begin
      if (eg[n]) begin
        e_a = a[n]; e_b = b[n]; e_ctrl = (c[n] > 4'd9) ? 4'd0 : c[n];
      end
    end
  endtask

  // Advance one clock and apply the accepted transactions to the model.
  task automatic tick();
    bit          v [2];
    logic [3:0]  c [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    bit          rr [2];
    bit          g [2];
    for (int n = 0; n < 2; n++) get_req(n, v[n], c[n], a[n], b[n]);
    rr[0] = bus.rsp0_ready;
    rr[1] = bus.rsp1_ready;
    predict();
    g[0] = eg[0];
    g[1] = eg[1];
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (g[n]) begin
        m_valid[n] = 1'b1;
        if (c[n] > 4'd9) begin
          m_result[n] = 32'd0; m_zero[n] = 1'b0; m_err[n] = 1'b1;
        end else begin
          m_result[n] = alu_ref(c[n], a[n], b[n]);
          m_zero[n]   = (m_result[n] == 32'd0);
          m_err[n]    = 1'b0;
        end
      end else if (rr[n]) begin
        m_valid[n] = 1'b0;
      end
    end
    if (g[0]) m_pref = 1'b1;
    else if (g[1]) m_pref = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    drive_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
    drive_req(1, 1'b1, 4'd0, 32'd3, 32'd4);
    drive_rsp(1'b1, 1'b1);
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready got %b expected 00", {bus.req1_ready, bus.req0_ready});
    end
    vectors++;
    if ({bus.rsp1_valid, bus.rsp0_valid, bus.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_valid_busy got %b expected 000", {bus.rsp1_valid, bus.rsp0_valid, bus.busy});
    end
    vectors++;
    if ({bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_rsp0 got %h expected 0", {bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result});
    end
    vectors++;
    if ({bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_rsp1 got %h expected 0", {bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result});
    end
    vectors++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_alu_drive got %h expected 0", {bus.alu_a, bus.alu_b, bus.alu_ctrl});
    end
    do_reset();
  endtask

  task automatic test_add();
    drive_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    #1;
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL add_ready got %b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    vectors++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== {32'd5, 32'd7, 4'd0}) begin
      miscompares++;
      $display("FAIL add_alu_drive got %h expected %h", {bus.alu_a, bus.alu_b, bus.alu_ctrl}, {32'd5, 32'd7, 4'd0});
    end
    tick();
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    vectors++;
    if ({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result, bus.busy} !== {3'b100, 32'd12, 1'b1}) begin
      miscompares++;
      $display("FAIL add_rsp0 got %h expected %h", {bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result, bus.busy}, {3'b100, 32'd12, 1'b1});
    end
    drive_rsp(1'b1, 1'b0);
    tick();
    vectors++;
    if ({bus.rsp0_valid, bus.rsp0_result, bus.busy} !== {1'b0, 32'd12, 1'b0}) begin
      miscompares++;
      $display("FAIL add_drain got %h expected %h", {bus.rsp0_valid, bus.rsp0_result, bus.busy}, {1'b0, 32'd12, 1'b0});
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    do_reset();
    drive_req(0, 1'b1, 4'd1, 32'd9, 32'd9);
    drive_req(1, 1'b1, 4'd1, 32'd9, 32'd9);
    drive_rsp(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      vectors++;
      if ({bus.req1_ready, bus.req0_ready} !== exp_g) begin
        miscompares++;
        $display("FAIL alt_grant[%0d] got %b expected %b", k, {bus.req1_ready, bus.req0_ready}, exp_g);
      end
      tick();
      vectors++;
      if (k % 2 == 0) begin
        if ({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result} !== {3'b101, 32'd0}) begin
          miscompares++;
          $display("FAIL alt_rsp0[%0d] got %h expected %h", k, {bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result}, {3'b101, 32'd0});
        end
      end else begin
        if ({bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result} !== {3'b101, 32'd0}) begin
          miscompares++;
          $display("FAIL alt_rsp1[%0d] got %h expected %h", k, {bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result}, {3'b101, 32'd0});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    drive_rsp(1'b1, 1'b0);
    drive_req(1, 1'b1, 4'd4, 32'h0000_00F0, 32'h0000_000F);
    for (int i = 0; i < 3; i++) begin
      drive_req(0, 1'b1, 4'd0, 32'(i), 32'd1);
      #1;
      vectors++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
        miscompares++;
        $display("FAIL bp_grant[%0d] got %b expected 01", i, {bus.req1_ready, bus.req0_ready});
      end
      tick();
      vectors++;
      if ({bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result} !== {3'b101, 32'd0}) begin
        miscompares++;
        $display("FAIL bp_rsp1_hold[%0d] got %h expected %h", i, {bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result}, {3'b101, 32'd0});
      end
      vectors++;
      if ({bus.rsp0_valid, bus.rsp0_result} !== {1'b1, 32'(i + 1)}) begin
        miscompares++;
        $display("FAIL bp_rsp0[%0d] got %h expected %h", i, {bus.rsp0_valid, bus.rsp0_result}, {1'b1, 32'(i + 1)});
      end
    end
    drive_rsp(1'b1, 1'b1);
    #1;
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_release_grant got %b expected 10", {bus.req1_ready, bus.req0_ready});
    end
    tick();
    vectors++;
    if ({bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result} !== {3'b100, 32'h0000_00FF}) begin
      miscompares++;
      $display("FAIL bp_rsp1_new got %h expected %h", {bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result}, {3'b100, 32'h0000_00FF});
    end
  endtask

  task automatic test_illegal();
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(0, 1'b1, 4'b1100, 32'd3, 32'd4);
    drive_rsp(1'b1, 1'b1);
    #1;
    vectors++;
    if ({bus.req1_ready, bus.req0_ready, bus.alu_ctrl} !== {2'b01, 4'b0000}) begin
      miscompares++;
      $display("FAIL illegal_drive got %b expected 010000", {bus.req1_ready, bus.req0_ready, bus.alu_ctrl});
    end
    tick();
    vectors++;
    if ({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result} !== {3'b110, 32'd0}) begin
      miscompares++;
      $display("FAIL illegal_rsp0 got %h expected %h", {bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result}, {3'b110, 32'd0});
    end
  endtask

  task automatic test_slt_sltu();
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1, 1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1);
    drive_rsp(1'b1, 1'b1);
    #1;
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL sltu_grant got %b expected 10", {bus.req1_ready, bus.req0_ready});
    end
    tick();
    vectors++;
    if ({bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result} !== {3'b101, 32'd0}) begin
      miscompares++;
      $display("FAIL sltu_rsp1 got %h expected %h", {bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result}, {3'b101, 32'd0});
    end
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(0, 1'b1, 4'd8, 32'hFFFF_FFFF, 32'd1);
    #1;
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL slt_grant got %b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    tick();
    vectors++;
    if ({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result} !== {3'b100, 32'd1}) begin
      miscompares++;
      $display("FAIL slt_rsp0 got %h expected %h", {bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result}, {3'b100, 32'd1});
    end
  endtask

  task automatic test_reset_midop();
    idle_all();
    drive_req(0, 1'b1, 4'd0, 32'd2, 32'd3);
    drive_rsp(1'b1, 1'b1);
    tick();
    drive_rsp(1'b0, 1'b0);
    drive_req(1, 1'b1, 4'd0, 32'd4, 32'd4);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.rsp1_valid, bus.rsp0_valid, bus.busy, bus.req1_ready, bus.req0_ready} !== 5'b00000) begin
      miscompares++;
      $display("FAIL midrst_drop got %b expected 00000", {bus.rsp1_valid, bus.rsp0_valid, bus.busy, bus.req1_ready, bus.req0_ready});
    end
    vectors++;
    if (bus.rsp0_result !== 32'd0) begin
      miscompares++;
      $display("FAIL midrst_result got %h expected 0", bus.rsp0_result);
    end
    drive_rsp(1'b1, 1'b1);
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.rsp0_valid, bus.req1_ready, bus.req0_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL midrst_hold got %b expected 000", {bus.rsp0_valid, bus.req1_ready, bus.req0_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_first_grant got %b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    tick();
    vectors++;
    if ({bus.rsp0_valid, bus.rsp0_result} !== {1'b1, 32'd5}) begin
      miscompares++;
      $display("FAIL midrst_rsp0 got %h expected %h", {bus.rsp0_valid, bus.rsp0_result}, {1'b1, 32'd5});
    end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a, b;
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom());
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom());
        drive_req(n, ($urandom_range(0, 3) != 0), c, a, b);
      end
      drive_rsp(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
      #1;
      predict();
      vectors++;
      if ({bus.req1_ready, bus.req0_ready} !== {eg[1], eg[0]}) begin
        miscompares++;
        $display("FAIL rnd_grant[%0d] got %b expected %b", i, {bus.req1_ready, bus.req0_ready}, {eg[1], eg[0]});
      end
      vectors++;
      if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== {e_a, e_b, e_ctrl}) begin
        miscompares++;
        $display("FAIL rnd_alu_drive[%0d] got %h expected %h", i, {bus.alu_a, bus.alu_b, bus.alu_ctrl}, {e_a, e_b, e_ctrl});
      end
      tick();
      vectors++;
      if ({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result} !== {m_valid[0], m_err[0], m_zero[0], m_result[0]}) begin
        miscompares++;
        $display("FAIL rnd_rsp0[%0d] got %h expected %h", i, {bus.rsp0_valid, bus.rsp0_err, bus.rsp0_zero, bus.rsp0_result}, {m_valid[0], m_err[0], m_zero[0], m_result[0]});
      end
      vectors++;
      if ({bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result} !== {m_valid[1], m_err[1], m_zero[1], m_result[1]}) begin
        miscompares++;
        $display("FAIL rnd_rsp1[%0d] got %h expected %h", i, {bus.rsp1_valid, bus.rsp1_err, bus.rsp1_zero, bus.rsp1_result}, {m_valid[1], m_err[1], m_zero[1], m_result[1]});
      end
      vectors++;
      if (bus.busy !== (m_valid[0] | m_valid[1])) begin
        miscompares++;
        $display("FAIL rnd_busy[%0d] got %b expected %b", i, bus.busy, (m_valid[0] | m_valid[1]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    idle_all();
    test_reset();
    test_add();
    test_alternate();
    test_backpressure();
    test_illegal();
    test_slt_sltu();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
